// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and flag bit positions shared by alu_seq and alu_seq_core
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_PASS = 4'd9;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int FLG_ZERO  = 0;
  localparam int FLG_NEG   = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 3;
endpackage

// File: rtl/alu_seq_core.sv
// alu_seq_core: combinational single-cycle ops and flags; SHL/SHR here cover only the zero-shift case (ans=a)
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       code,
  output logic [WIDTH-1:0] ans,
  output logic [3:0]       flags,
  output logic             err
);
  logic [WIDTH:0] sum, dif;
  logic carry, ovf;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  always_comb begin
    ans = '0;
    carry = 1'b0;
    ovf = 1'b0;
    err = 1'b0;
    case (code)
      OP_ADD: begin
        ans = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        ans = dif[WIDTH-1:0];
        carry = dif[WIDTH];
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: ans = a & b;
      OP_OR: ans = a | b;
      OP_XOR: ans = a ^ b;
      OP_NOT: ans = ~a;
      OP_SHL, OP_SHR: ans = a;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: ans = '0;
`endif
      OP_PASS: ans = b;
      default: err = 1'b1;
    endcase
    flags = err ? 4'b0 : {ovf, carry, ans[WIDTH-1], ~|ans};
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered valid/ready ALU with iterative shifts; define ALU_SEQ_MUL_EN to add the shift-add multiplier (opcode 8)
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic [3:0]       flags,
  output logic             err
);
  localparam int CW = SHAMT_W + 1;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
  logic [WIDTH-1:0] opa, hi;
  logic [WIDTH:0] msum;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic [1:0] st;
  logic [3:0] opc, c_flags;
  logic [WIDTH-1:0] acc, nxt, c_ans;
  logic [CW-1:0] cnt;
  logic c_err, cout, iter;
  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .a(a),
    .b(b),
    .code(code),
    .ans(c_ans),
    .flags(c_flags),
    .err(c_err)
  );
  assign in_ready = st == ST_IDLE;
  assign out_valid = st == ST_DONE;
  assign iter = ((code == OP_SHL || code == OP_SHR) && |b[SHAMT_W-1:0]) || (MUL_EN && code == OP_MUL);
  // acc holds the shifting value, or the multiplier/low product half during MUL
  always_comb begin
    nxt = opc == OP_SHL ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};
    cout = opc == OP_SHL ? acc[WIDTH-1] : acc[0];
`ifdef ALU_SEQ_MUL_EN
    msum = {1'b0, hi} + (acc[0] ? {1'b0, opa} : '0);
    if (opc == OP_MUL) begin
      nxt = {msum[0], acc[WIDTH-1:1]};
      cout = |msum[WIDTH:1];
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= ST_IDLE;
      opc <= '0;
      acc <= '0;
      cnt <= '0;
      ans <= '0;
      flags <= '0;
      err <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      opa <= '0;
      hi <= '0;
`endif
    end else begin
      case (st)
        ST_IDLE: if (in_valid) begin
          if (iter) begin
            st <= ST_BUSY;
            opc <= code;
            acc <= code == OP_MUL ? b : a;
            cnt <= code == OP_MUL ? CW'(WIDTH) : CW'(b[SHAMT_W-1:0]);
`ifdef ALU_SEQ_MUL_EN
            opa <= a;
            hi <= '0;
`endif
          end else begin
            st <= ST_DONE;
            ans <= c_ans;
            flags <= c_flags;
            err <= c_err;
          end
        end
        ST_BUSY: begin
          acc <= nxt;
          cnt <= cnt - CW'(1);
`ifdef ALU_SEQ_MUL_EN
          hi <= msum[WIDTH:1];
`endif
          if (cnt == CW'(1)) begin
            st <= ST_DONE;
            ans <= nxt;
            flags <= {1'b0, cout, nxt[WIDTH-1], ~|nxt};
            err <= 1'b0;
          end
        end
        ST_DONE: if (out_ready) st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with a queue scoreboard checked by an independent output monitor
module tb_alu_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, err;
  logic [7:0] a = '0, b = '0, ans;
  logic [3:0] code = '0, flags;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    string nm;
    logic [7:0] ans;
    logic [3:0] flags;
    logic err;
    int lat;
    int acc;
  } exp_t;
  exp_t q[$];
  alu_seq #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .code(code),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ans(ans),
    .flags(flags),
    .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    bit seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && !seen) begin
        if (q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = q.pop_front();
          chk({e.nm, "_ans"}, ans, e.ans);
          chk({e.nm, "_flags"}, flags, e.flags);
          chk({e.nm, "_err"}, err, e.err);
          chk({e.nm, "_lat"}, cyc - e.acc + 1, e.lat);
        end
      end
      seen = rst_n && out_valid;
    end
  end
  task automatic issue(input logic [3:0] c, input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] ea, input logic [3:0] ef, input logic ee,
                       input int lat, input string nm, input bit push);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    code = c;
    a = va;
    b = vb;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({nm, "_accept_timeout"}, 1, 0);
    else if (push) q.push_back('{nm, ea, ef, ee, lat, cyc + 1});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({nm, "_idle_timeout"}, 1, 0);
  endtask
  task automatic run(input logic [3:0] c, input logic [7:0] va, input logic [7:0] vb,
                     input logic [7:0] ea, input logic [3:0] ef, input logic ee,
                     input int lat, input string nm);
    issue(c, va, vb, ea, ef, ee, lat, nm, 1'b1);
    wait_idle(nm);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ans", ans, 0);
    chk("rst_flags", flags, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    // flags are {ovf, carry, neg, zero}
    run(4'd0, 8'h7F, 8'h01, 8'h80, 4'b1010, 1'b0, 1, "add_ovf");
    run(4'd0, 8'hFF, 8'h01, 8'h00, 4'b0101, 1'b0, 1, "add_carry");
    run(4'd1, 8'h03, 8'h05, 8'hFE, 4'b0110, 1'b0, 1, "sub_borrow");
    run(4'd1, 8'h05, 8'h05, 8'h00, 4'b0001, 1'b0, 1, "sub_zero");
    run(4'd1, 8'h80, 8'h01, 8'h7F, 4'b1000, 1'b0, 1, "sub_ovf");
    run(4'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0, 1, "and");
    run(4'd3, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0, 1, "or_zero");
    run(4'd5, 8'h0F, 8'h00, 8'hF0, 4'b0010, 1'b0, 1, "not");
    run(4'd9, 8'h11, 8'h7E, 8'h7E, 4'b0000, 1'b0, 1, "pass");
    run(4'd6, 8'h81, 8'h03, 8'h08, 4'b0000, 1'b0, 4, "shl3");
    run(4'd6, 8'h01, 8'h07, 8'h80, 4'b0010, 1'b0, 8, "shl7");
    run(4'd7, 8'h81, 8'h00, 8'h81, 4'b0010, 1'b0, 1, "shr0");
    run(4'd7, 8'h81, 8'h01, 8'h40, 4'b0100, 1'b0, 2, "shr1");
    run(4'd7, 8'h81, 8'hF9, 8'h40, 4'b0100, 1'b0, 2, "shr_amt_lowbits");
`ifdef ALU_SEQ_MUL_EN
    run(4'd8, 8'h10, 8'h11, 8'h10, 4'b0100, 1'b0, 9, "mul_hi");
    run(4'd8, 8'h0F, 8'h0F, 8'hE1, 4'b0010, 1'b0, 9, "mul_lo");
`else
    run(4'd8, 8'h10, 8'h11, 8'h00, 4'b0000, 1'b1, 1, "mul_disabled");
`endif
    run(4'd12, 8'hAA, 8'h55, 8'h00, 4'b0000, 1'b1, 1, "illegal12");
    run(4'd15, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b1, 1, "illegal15");
    out_ready = 1'b0;
    issue(4'd4, 8'hF0, 8'hFF, 8'h0F, 4'b0000, 1'b0, 1, "xor_bp", 1'b1);
    in_valid = 1'b1;
    code = 4'd0;
    a = 8'h01;
    b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ans", ans, 8'h0F);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    issue(4'd6, 8'h01, 8'h07, 8'h00, 4'b0000, 1'b0, 0, "rst_shl", 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_ans", ans, 0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef ALU_SEQ_MUL_EN
    issue(4'd8, 8'h10, 8'h11, 8'h00, 4'b0000, 1'b0, 0, "rst_mul", 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_mul_out_valid", out_valid, 0);
    chk("abort_mul_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
`endif
    repeat (12) @(negedge clk);
    chk("post_abort_idle", in_ready, 1);
    run(4'd12, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b1, 1, "illegal_after_rst");
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
